// File: rtl/taylor_exp_kernel.sv
// Iterative Taylor-series evaluator for e^(+/-x), x an unsigned fraction.
// One series term per cycle; the result is clamped to the unsigned output range.
module taylor_exp_kernel #(
  parameter int FRAC_W     = 8,
  parameter int INT_W      = 2,
  parameter int N_TERMS    = 4,
  parameter int EARLY_EXIT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [FRAC_W-1:0]       in_data,
  input  logic                    in_sign,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [INT_W+FRAC_W-1:0] out_data,
  output logic                    out_sat,
  output logic [2:0]              out_terms
);

  localparam int OW    = INT_W + FRAC_W;
  localparam int SW    = OW + 2;
  localparam int ONE_I = 1 << FRAC_W;
  localparam int MAX_I = (1 << OW) - 1;

  localparam logic signed [SW-1:0] ONE_S = SW'(ONE_I);
  localparam logic signed [SW-1:0] MAX_S = SW'(MAX_I);

  localparam logic [FRAC_W-1:0] R2 = FRAC_W'(ONE_I / 2);
  localparam logic [FRAC_W-1:0] R3 = FRAC_W'(ONE_I / 3);
  localparam logic [FRAC_W-1:0] R4 = FRAC_W'(ONE_I / 4);
  localparam logic [FRAC_W-1:0] R5 = FRAC_W'(ONE_I / 5);
  localparam logic [FRAC_W-1:0] R6 = FRAC_W'(ONE_I / 6);
  localparam logic [FRAC_W-1:0] R7 = FRAC_W'(ONE_I / 7);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [FRAC_W-1:0]     x_q, x_d;
  logic [FRAC_W-1:0]     term_q, term_d;
  logic                  sign_q, sign_d;
  logic [2:0]            k_q, k_d;
  logic signed [SW-1:0]  sum_q, sum_d;
  logic [OW-1:0]         out_data_q, out_data_d;
  logic                  out_sat_q, out_sat_d;
  logic [2:0]            out_terms_q, out_terms_d;

  logic [FRAC_W-1:0]     rk;
  logic [2*FRAC_W-1:0]   prod_tx;
  logic [2*FRAC_W-1:0]   prod_pr;
  logic [FRAC_W-1:0]     p;
  logic [FRAC_W-1:0]     term_next;
  logic signed [SW-1:0]  tn_ext;
  logic signed [SW-1:0]  in_ext;
  logic signed [SW-1:0]  sum_iter;
  logic                  last;

  always_comb begin
    rk = '0;
    unique case (k_q)
      3'd2:    rk = R2;
      3'd3:    rk = R3;
      3'd4:    rk = R4;
      3'd5:    rk = R5;
      3'd6:    rk = R6;
      3'd7:    rk = R7;
      default: rk = '0;
    endcase
  end

  // term_{k} = ((term_{k-1} * x) >> F) * (1/k) >> F, both truncating
  always_comb begin
    prod_tx   = {{FRAC_W{1'b0}}, term_q} * {{FRAC_W{1'b0}}, x_q};
    p         = FRAC_W'(prod_tx >> FRAC_W);
    prod_pr   = {{FRAC_W{1'b0}}, p} * {{FRAC_W{1'b0}}, rk};
    term_next = FRAC_W'(prod_pr >> FRAC_W);
    tn_ext    = {{(SW-FRAC_W){1'b0}}, term_next};
    in_ext    = {{(SW-FRAC_W){1'b0}}, in_data};
    if (sign_q && k_q[0])
      sum_iter = sum_q - tn_ext;
    else
      sum_iter = sum_q + tn_ext;
    last = (k_q == 3'(N_TERMS)) ||
           ((EARLY_EXIT != 0) && (term_next == '0));
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    term_d      = term_q;
    sign_d      = sign_q;
    k_d         = k_q;
    sum_d       = sum_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_terms_d = out_terms_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = in_data;
          sign_d  = in_sign;
          term_d  = in_data;
          sum_d   = in_sign ? (ONE_S - in_ext) : (ONE_S + in_ext);
          k_d     = 3'd2;
          state_d = ITER;
        end
      end
      ITER: begin
        sum_d  = sum_iter;
        term_d = term_next;
        k_d    = k_q + 3'd1;
        if (last) begin
          state_d     = DONE;
          out_terms_d = k_q;
          if (sum_iter < 0) begin
            out_data_d = '0;
            out_sat_d  = 1'b1;
          end else if (sum_iter > MAX_S) begin
            out_data_d = MAX_S[OW-1:0];
            out_sat_d  = 1'b1;
          end else begin
            out_data_d = sum_iter[OW-1:0];
            out_sat_d  = 1'b0;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      term_q      <= '0;
      sign_q      <= 1'b0;
      k_q         <= '0;
      sum_q       <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_terms_q <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      term_q      <= term_d;
      sign_q      <= sign_d;
      k_q         <= k_d;
      sum_q       <= sum_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_terms_q <= out_terms_d;
    end
  end

  // Ready is masked while reset is held so nothing is offered during it.
  assign in_ready  = (state_q == IDLE) && rst_n;
  assign out_valid = (state_q == DONE);
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_terms = out_terms_q;

endmodule

// File: doc/taylor_exp_kernel.md
TAYLOR_EXP_KERNEL -- requirements
Module: taylor_exp_kernel

Interface
REQ-001: The block SHALL have parameter FRAC_W, default 8, giving fraction bits of input and output; legal range 4..16.
REQ-002: The block SHALL have parameter INT_W, default 2, giving integer bits of output; legal range 1..4.
REQ-003: The block SHALL have parameter N_TERMS, default 4, giving the highest series power evaluated; legal range 2..7.
REQ-004: The block SHALL have parameter EARLY_EXIT, default 1; when 1, iteration stops once a computed term is zero.
REQ-005: clk  input  1  clock; all state changes on rising edge.
REQ-006: rst_n  input  1  reset, asynchronous, active-low.
REQ-007: in_valid  input  1  input operand present.
REQ-008: in_ready  output  1  block can accept an operand.
REQ-009: in_data  input  FRAC_W  |t|, unsigned pure fraction UQ0.FRAC_W.
REQ-010: in_sign  input  1  1 = evaluate e^(-|t|), 0 = e^(+|t|).
REQ-011: out_valid  output  1  result present.
REQ-012: out_ready  input  1  consumer takes result.
REQ-013: out_data  output  INT_W+FRAC_W  result, unsigned UQ INT_W.FRAC_W.
REQ-014: out_sat  output  1  result was clamped.
REQ-015: out_terms  output  3  highest power actually added (1..N_TERMS).

Function
REQ-016: The block SHALL compute S = sum over k=0..N_TERMS of (s*x)^k / k!, s = -1 if in_sign else +1, x = in_data / 2^FRAC_W.
REQ-017: The block SHALL implement a three-state FSM: IDLE, ITER, DONE.
REQ-018: in_ready SHALL equal 1 in IDLE only; a transfer occurs on an edge with in_valid & in_ready.
REQ-019: On transfer: x <= in_data, sign <= in_sign, term <= in_data, sum <= 2^FRAC_W - in_data (sign=1) or 2^FRAC_W + in_data (sign=0), k <= 2, state <= ITER.
REQ-020: Each ITER cycle: p = (term*x) >> FRAC_W; term_next = (p*RECIP[k]) >> FRAC_W, both truncating; RECIP[k] = floor(2^FRAC_W / k), k = 2..7, constant table.
REQ-021: Each ITER cycle: sum <= sum - term_next if sign=1 and k odd, else sum + term_next; term <= term_next; k <= k+1.
REQ-022: ITER SHALL go to DONE when k == N_TERMS, or when EARLY_EXIT=1 and term_next == 0 (that zero term still counted as added).
REQ-023: Latency from transfer edge to out_valid SHALL be exactly N_TERMS-1 cycles without early exit; fewer with early exit.
REQ-024: sum SHALL be held internally at INT_W+FRAC_W+2 bits, signed, so no intermediate wrap occurs.
REQ-025: out_data SHALL be sum clamped to [0, 2^(INT_W+FRAC_W)-1]; out_sat = 1 iff a clamp applied.
REQ-026: out_terms SHALL be k-1 at DONE entry.
REQ-027: out_valid SHALL be 1 in DONE only; out_data, out_sat, out_terms SHALL stay stable while out_valid & !out_ready.
REQ-028: DONE with out_ready SHALL return to IDLE next edge; no same-cycle bypass from DONE to a new transfer.
REQ-029: in_data and in_sign SHALL be ignored outside a transfer edge.

Reset
REQ-030: rst_n low SHALL immediately force state IDLE, sum/term/x/k/sign to 0, out_valid 0, out_sat 0, out_terms 0, out_data 0, in_ready 0 while asserted, in_ready 1 after release.
REQ-031: Reset asserted mid-ITER or mid-DONE SHALL discard the operation; no out_valid after release until a new transfer.

Verification
REQ-032: Defaults; in_data=128, in_sign=0, out_ready=1 -> out_data=421 (0x1A5), out_terms=4, out_sat=0, out_valid 3 cycles after transfer.
REQ-033: Defaults; in_data=128, in_sign=1 -> out_data=155, out_terms=4.
REQ-034: Defaults; in_data=0, in_sign=0 -> out_data=256, out_terms=2, out_valid 1 cycle after transfer (early exit).
REQ-035: INT_W=1, N_TERMS=7; in_data=255, in_sign=0 -> out_data=511, out_sat=1.
REQ-036: out_ready held 0 for 5 cycles at DONE -> out_valid and out_data stable, in_ready 0 throughout; second operand accepted only after release plus one IDLE cycle.
REQ-037: rst_n pulsed low during ITER -> out_valid never asserted for that operand; next operand produces correct result.
